// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 8-bit CPU: sequences FETCH/DECODE/EXEC/MEM/WB,
// handshakes with fetch and data memory, and counts retired instructions.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 4,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero_flag,
  input  logic                mem_ready,
  output logic                fetch_req,
  output logic                ir_load,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                pc_write,
  output logic                pc_inc,
  output logic                illegal_op,
  output logic                mem_err,
  output logic                halted,
  output logic [CNT_W-1:0]    instr_count
);

  localparam int TMO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_MOV   = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd5;
  localparam logic [3:0] OP_STORE = 4'd6;
  localparam logic [3:0] OP_LI    = 4'd7;
  localparam logic [3:0] OP_JMP   = 4'd8;
  localparam logic [3:0] OP_BEQ   = 4'd9;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]    count_q;
  logic [3:0]          op_low;
  logic                upper_zero;
  logic                legal;
  logic                retire;
  logic [2:0]          alu3;

  assign op_low     = op_q[3:0];
  assign upper_zero = ((op_q >> 4) == '0);
  assign legal      = upper_zero && !(op_low >= 4'd10 && op_low <= 4'd14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      tmo_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (state_q == S_FETCH && instr_valid)
        op_q <= opcode;
      if (retire)
        count_q <= count_q + CNT_W'(1);
    end
  end

  // Everything is gated by rst_n so all strobes drop the instant reset asserts.
  always_comb begin
    state_d    = state_q;
    tmo_d      = '0;
    retire     = 1'b0;
    alu3       = 3'b000;
    fetch_req  = 1'b0;
    ir_load    = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    pc_inc     = 1'b0;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    halted     = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          fetch_req = 1'b1;
          if (instr_valid) begin
            ir_load = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          if (!legal) begin
            illegal_op = 1'b1;
            pc_inc     = 1'b1;
            state_d    = S_FETCH;
          end else begin
            case (op_low)
              OP_ADD, OP_MOV: state_d = S_WB;
              OP_SUB: begin alu3 = 3'b001; state_d = S_WB; end
              OP_AND: begin alu3 = 3'b010; state_d = S_WB; end
              OP_OR:  begin alu3 = 3'b011; state_d = S_WB; end
              OP_LI:  begin alu_src = 1'b1; state_d = S_WB; end
              OP_LOAD, OP_STORE: begin alu_src = 1'b1; state_d = S_MEM; end
              OP_JMP: begin
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
              end
              OP_BEQ: begin
                alu3     = 3'b001;
                pc_write = zero_flag;
                pc_inc   = !zero_flag;
                retire   = 1'b1;
                state_d  = S_FETCH;
              end
              OP_HALT: begin
                retire  = 1'b1;
                state_d = S_HALT;
              end
              default: state_d = S_FETCH;
            endcase
          end
        end
        // Ready on the final allowed cycle wins over the timeout.
        S_MEM: begin
          alu_src   = 1'b1;
          mem_read  = (op_low == OP_LOAD);
          mem_write = (op_low != OP_LOAD);
          if (mem_ready) begin
            if (op_low == OP_LOAD) begin
              state_d = S_WB;
            end else begin
              pc_inc  = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end else if (tmo_q == TMO_LAST) begin
            mem_err = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_FETCH;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_inc    = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_HALT:  halted  = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    alu_op      = '0;
    alu_op[2:0] = alu3;
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for multicycle_control_unit: expected output vectors are
// queued as each cycle's stimulus is driven and compared mid-cycle.
module tb_multicycle_control_unit;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [3:0] opcode;
  logic       zero_flag;
  logic       mem_ready;
  logic       fetch_req, ir_load, alu_src, reg_write, mem_read, mem_write;
  logic       pc_write, pc_inc, illegal_op, mem_err, halted;
  logic [2:0] alu_op;
  logic [3:0] instr_count;

  typedef struct packed {
    logic       fetch_req;
    logic       ir_load;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       pc_inc;
    logic       illegal_op;
    logic       mem_err;
    logic       halted;
    logic [3:0] count;
  } outs_t;

  outs_t      sb_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt = 4'd0;

  multicycle_control_unit #(
    .OPCODE_W(4), .ALU_OP_W(3), .MEM_TIMEOUT(TMO), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .opcode(opcode),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .fetch_req(fetch_req),
    .ir_load(ir_load), .alu_op(alu_op), .alu_src(alu_src), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .pc_write(pc_write), .pc_inc(pc_inc),
    .illegal_op(illegal_op), .mem_err(mem_err), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic outs_t blank();
    outs_t o;
    o       = '0;
    o.count = exp_cnt;
    return o;
  endfunction

  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic z,
                               input logic r, input outs_t e);
    instr_valid = v;
    opcode      = op;
    zero_flag   = z;
    mem_ready   = r;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    outs_t obs, e;
    obs = {fetch_req, ir_load, alu_op, alu_src, reg_write, mem_read, mem_write,
           pc_write, pc_inc, illegal_op, mem_err, halted, instr_count};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic step(input logic v, input logic [3:0] op, input logic z,
                      input logic r, input outs_t e, input string tag);
    applyStimulus(v, op, z, r, e);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  // waits < 0 means mem_ready never arrives
  task automatic run_instr(input logic [3:0] op, input logic z, input int waits);
    outs_t e;
    logic  rdy;
    logic  ok;
    e = blank(); e.fetch_req = 1'b1; e.ir_load = 1'b1;
    step(1'b1, op, 1'b0, 1'b0, e, "fetch");
    e = blank();
    step(1'b0, ~op, 1'b0, 1'b0, e, "decode");
    e = blank();
    case (op)
      4'd1:             e.alu_op = 3'b001;
      4'd2:             e.alu_op = 3'b010;
      4'd3:             e.alu_op = 3'b011;
      4'd5, 4'd6, 4'd7: e.alu_src = 1'b1;
      4'd8:             e.pc_write = 1'b1;
      4'd9: begin
        e.alu_op   = 3'b001;
        e.pc_write = z;
        e.pc_inc   = !z;
      end
      4'd0, 4'd4, 4'd15: ;
      default: begin
        e.illegal_op = 1'b1;
        e.pc_inc     = 1'b1;
      end
    endcase
    step(1'b0, ~op, z, 1'b0, e, "exec");
    if (op == 4'd8 || op == 4'd9 || op == 4'd15) exp_cnt = exp_cnt + 4'd1;
    ok = (op <= 4'd4 || op == 4'd7);
    if (op == 4'd5 || op == 4'd6) begin
      for (int i = 0; i < TMO; i++) begin
        rdy = (waits == i);
        e = blank();
        e.alu_src   = 1'b1;
        e.mem_read  = (op == 4'd5);
        e.mem_write = (op == 4'd6);
        if (rdy) e.pc_inc = (op == 4'd6);
        else if (i == TMO - 1) begin
          e.mem_err = 1'b1;
          e.pc_inc  = 1'b1;
        end
        step(1'b0, ~op, 1'b0, rdy, e, "mem");
        if (rdy) break;
      end
      if (waits >= 0 && waits < TMO) begin
        if (op == 4'd6) exp_cnt = exp_cnt + 4'd1;
        else ok = 1'b1;
      end
    end
    if (ok) begin
      e = blank(); e.reg_write = 1'b1; e.pc_inc = 1'b1;
      step(1'b0, ~op, 1'b0, 1'b0, e, "wb");
      exp_cnt = exp_cnt + 4'd1;
    end
  endtask

  initial begin
    outs_t e;
    logic [3:0] mix [8];
    mix = '{4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
    rst_n = 1'b0; instr_valid = 1'b0; opcode = 4'd0; zero_flag = 1'b0; mem_ready = 1'b0;
    #3;
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, blank());
    #1 checkOutput("reset_state");
    instr_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    e = blank(); e.fetch_req = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b0, e, "idle_fetch");

    run_instr(4'd0, 1'b0, 0);
    run_instr(4'd9, 1'b1, 0);
    run_instr(4'd9, 1'b0, 0);
    run_instr(4'd5, 1'b0, 3);
    run_instr(4'd6, 1'b0, -1);
    run_instr(4'd10, 1'b0, 0);
    run_instr(4'd6, 1'b0, TMO - 1);
    run_instr(4'd5, 1'b0, 0);
    run_instr(4'd1, 1'b0, 0);
    run_instr(4'd2, 1'b0, 0);
    run_instr(4'd3, 1'b0, 0);
    run_instr(4'd4, 1'b0, 0);
    run_instr(4'd7, 1'b0, 0);

    e = blank(); e.fetch_req = 1'b1; e.ir_load = 1'b1;
    step(1'b1, 4'd5, 1'b0, 1'b0, e, "rst_fetch");
    e = blank();
    step(1'b0, 4'd0, 1'b0, 1'b0, e, "rst_decode");
    e = blank(); e.alu_src = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b0, e, "rst_exec");
    e = blank(); e.alu_src = 1'b1; e.mem_read = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, e);
    @(negedge clk);
    checkOutput("mem_pre_reset");
    #2 rst_n = 1'b0;
    exp_cnt = 4'd0;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, blank());
    #1 checkOutput("reset_async");
    @(posedge clk); #1;
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b1, blank());
    checkOutput("reset_hold");
    instr_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    e = blank(); e.fetch_req = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b0, e, "post_reset_fetch");

    for (int i = 0; i < 16; i++) run_instr(mix[i % 8], i[0], 0);
    run_instr(4'd15, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      e = blank(); e.halted = 1'b1;
      step(1'b1, 4'd0, 1'b0, 1'b1, e, "halted");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
